// File: rtl/bitonic_sort_loader_if.sv
// Stream-in / frame-out bundle for bitonic_sort_loader.
// slave: loader side; master: upstream producer plus downstream sorter side.
// SORT_LOADER_COUNT_EN adds the out_count signal to the bundle.
interface bitonic_sort_loader_if #(
  parameter int W = 1,
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_array;
`ifdef SORT_LOADER_COUNT_EN
  logic [$clog2(N+1)-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_array, out_count
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_array, out_count
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_array
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_array
  );
`endif
endinterface

// File: rtl/bitonic_sort_loader.sv
// Packs a serial element stream into N-wide frames for the bitonic sorter.
// Fill buffer collects elements; hold buffer presents a stable frame downstream.
// Short frames (in_last) are padded with all-ones or all-zeros (PAD_ONE).
// Optional: SORT_LOADER_COUNT_EN adds out_count (real elements in the held frame).
//
// state   | meaning
// S_FILL  | accepting elements into the fill buffer
// S_STALL | fill buffer holds a closed frame, waiting for the hold buffer to free
module bitonic_sort_loader #(
  parameter int W       = 1,
  parameter int N       = 4,
  parameter int PAD_ONE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitonic_sort_loader_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [W-1:0] PAD = (PAD_ONE != 0) ? {W{1'b1}} : {W{1'b0}};

  typedef enum logic {S_FILL = 1'b0, S_STALL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   fill_q [N];
  logic [N*W-1:0] hold_q;
  logic           out_valid_q;
  logic           in_ready_q;

  logic           accept;
  logic           close;
  logic           consume;
  logic           hold_free;
  logic           ld_from_in;
  logic           ld_from_fill;
  logic           park;
  logic           in_ready_d;
  logic [N*W-1:0] frame_in;
  logic [N*W-1:0] fill_flat;

  assign accept    = bus.in_valid & in_ready_q;
  assign close     = accept & ((idx_q == IW'(N - 1)) | bus.in_last);
  assign consume   = out_valid_q & bus.out_ready;
  assign hold_free = ~out_valid_q | bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  // Next-state: a closed frame parks in the fill buffer only if hold is busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (close && !hold_free) state_d = S_STALL;
      S_STALL: if (consume)             state_d = S_FILL;
      default:                          state_d = S_FILL;
    endcase
  end

  // Datapath controls derived from state and handshakes
  always_comb begin
    ld_from_in   = 1'b0;
    ld_from_fill = 1'b0;
    park         = 1'b0;
    in_ready_d   = (state_d == S_FILL);
    case (state_q)
      S_FILL: begin
        ld_from_in = close & hold_free;
        park       = close & ~hold_free;
      end
      S_STALL: ld_from_fill = consume;
      default: ;
    endcase
  end

  // Closing frame as seen this cycle: stored slots, incoming element, then pad
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(idx_q))       frame_in[k*W +: W] = fill_q[k];
      else if (k == int'(idx_q)) frame_in[k*W +: W] = bus.in_data;
      else                       frame_in[k*W +: W] = PAD;
    end
  end

  // Flattened fill buffer for the STALL -> hold transfer
  always_comb begin
    fill_flat = '0;
    for (int k = 0; k < N; k++) fill_flat[k*W +: W] = fill_q[k];
  end

  // in_ready registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready_q <= 1'b0;
    else        in_ready_q <= in_ready_d;
  end

  // Fill buffer and slot index; idx stays on the closing slot while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int k = 0; k < N; k++) fill_q[k] <= '0;
    end else if (ld_from_in || ld_from_fill) begin
      idx_q <= '0;
    end else if (park) begin
      for (int k = 0; k < N; k++) fill_q[k] <= frame_in[k*W +: W];
    end else if (accept) begin
      fill_q[idx_q] <= bus.in_data;
      idx_q         <= IW'(idx_q + 1'b1);
    end
  end

  // Hold buffer: a new frame replaces a consumed one on the same edge, no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (ld_from_in) begin
      hold_q      <= frame_in;
      out_valid_q <= 1'b1;
    end else if (ld_from_fill) begin
      hold_q      <= fill_flat;
      out_valid_q <= 1'b1;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef SORT_LOADER_COUNT_EN
  logic [CW-1:0] count_q;

  // Element count follows the frame into hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        count_q <= '0;
    else if (ld_from_in || ld_from_fill) count_q <= CW'(idx_q) + CW'(1);
  end

  assign bus.out_count = count_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_array = hold_q;
endmodule

// File: tb/tb_bitonic_sort_loader.sv
// Directed bench for bitonic_sort_loader (N=4, W=1); a second instance with
// PAD_ONE=0 shares the same stimulus to check zero padding.
// out_count checks are compiled in only with SORT_LOADER_COUNT_EN.
module tb_bitonic_sort_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  int   drops = 0;
  logic [3:0] cap[$];
  logic [3:0] fr [4];

  always #5 clk = ~clk;

  bitonic_sort_loader_if #(.W(1), .N(4)) bus ();
  bitonic_sort_loader_if #(.W(1), .N(4)) bus_z ();

  bitonic_sort_loader #(.W(1), .N(4), .PAD_ONE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  bitonic_sort_loader #(.W(1), .N(4), .PAD_ONE(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(bus_z)
  );

  assign bus_z.in_valid  = bus.in_valid;
  assign bus_z.in_data   = bus.in_data;
  assign bus_z.in_last   = bus.in_last;
  assign bus_z.out_ready = bus.out_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one element and return #1 after the edge that accepts it (in_valid left high)
  task automatic send(input logic d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_val("send_timeout", 32'(bus.in_ready), 1);
    tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) cap.push_back(bus.out_array);
      if (!bus.in_ready) drops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    fr[0] = 4'b1011; fr[1] = 4'b0100; fr[2] = 4'b1111; fr[3] = 4'b0010;

    // Reset state
    repeat (3) tick();
    check_val("rst_in_ready", 32'(bus.in_ready), 0);
    check_val("rst_out_valid", 32'(bus.out_valid), 0);
    check_val("rst_out_array", 32'(bus.out_array), 0);
`ifdef SORT_LOADER_COUNT_EN
    check_val("rst_out_count", 32'(bus.out_count), 0);
`endif
    rst_n = 1'b1;
    tick();
    check_val("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Mid-frame reset discards the two buffered elements
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_in_ready", 32'(bus.in_ready), 0);
    check_val("midrst_out_valid", 32'(bus.out_valid), 0);
    check_val("midrst_out_array", 32'(bus.out_array), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full frame 1,0,1,0 with out_ready=1
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check_val("full_pre_valid", 32'(bus.out_valid), 0);
    send(1'b0, 1'b0);
    bus.in_valid = 1'b0;
    check_val("full_valid", 32'(bus.out_valid), 1);
    check_val("full_array", 32'(bus.out_array), 32'h5);
    check_val("full_array_z", 32'(bus_z.out_array), 32'h5);
`ifdef SORT_LOADER_COUNT_EN
    check_val("full_count", 32'(bus.out_count), 4);
`endif
    tick();
    check_val("full_consumed", 32'(bus.out_valid), 0);

    // Short frame 0,(gap),0+last with hold stalled
    bus.out_ready = 1'b0;
    send(1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check_val("gap_no_frame", 32'(bus.out_valid), 0);
    send(1'b0, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_val("short_valid", 32'(bus.out_valid), 1);
    check_val("short_array", 32'(bus.out_array), 32'hC);
    check_val("short_array_z", 32'(bus_z.out_array), 32'h0);
`ifdef SORT_LOADER_COUNT_EN
    check_val("short_count", 32'(bus.out_count), 2);
`endif
    repeat (2) tick();
    check_val("short_hold_valid", 32'(bus.out_valid), 1);
    check_val("short_hold_array", 32'(bus.out_array), 32'hC);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_val("short_consumed", 32'(bus.out_valid), 0);

    // Backpressure: frames 1,0,0,0 then 0,1,1,1 with out_ready=0
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    check_val("bp_a_array", 32'(bus.out_array), 32'h1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    bus.in_valid = 1'b0;
    check_val("bp_stall_in_ready", 32'(bus.in_ready), 0);
    check_val("bp_a_stable", 32'(bus.out_array), 32'h1);
    repeat (2) tick();
    check_val("bp_stall_hold", 32'(bus.in_ready), 0);
    check_val("bp_a_still", 32'(bus.out_array), 32'h1);
    bus.out_ready = 1'b1;
    tick();
    check_val("bp_b_valid", 32'(bus.out_valid), 1);
    check_val("bp_b_array", 32'(bus.out_array), 32'hE);
    check_val("bp_b_in_ready", 32'(bus.in_ready), 1);
`ifdef SORT_LOADER_COUNT_EN
    check_val("bp_b_count", 32'(bus.out_count), 4);
`endif
    tick();
    check_val("bp_b_consumed", 32'(bus.out_valid), 0);

    // Back-to-back: 16 elements, out_ready=1 throughout
    cap.delete();
    drops = 0;
    mon_en = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < 4; j++) begin
        logic [3:0] v;
        v = fr[f];
        send(v[j], 1'b0);
      end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    mon_en = 1'b0;
    check_val("b2b_frames", 32'(cap.size()), 4);
    check_val("b2b_in_ready_drops", 32'(drops), 0);
    if (cap.size() == 4)
      for (int f = 0; f < 4; f++) check_val($sformatf("b2b_frame%0d", f), 32'(cap[f]), 32'(fr[f]));

    // in_last on the final slot: one frame only, next frame starts at slot 0
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_val("lastfull_array", 32'(bus.out_array), 32'hF);
    tick();
    check_val("lastfull_consumed", 32'(bus.out_valid), 0);
    tick();
    check_val("lastfull_no_extra", 32'(bus.out_valid), 0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_val("after_last_array", 32'(bus.out_array), 32'hE);
    check_val("after_last_array_z", 32'(bus_z.out_array), 32'h2);
`ifdef SORT_LOADER_COUNT_EN
    check_val("after_last_count", 32'(bus.out_count), 2);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
